param_alu_core: RTL and testbench

//  Parametrised successor of the 8-bit TinyALU DUT: unsigned ALU, DATA_W-bit operands, 2*DATA_W-bit result.

---
 rtl/param_alu_core.sv | 141 ++++++++++++++
 tb/tb_param_alu_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/param_alu_core.sv
// Unsigned ALU with start/done handshake: single-cycle add/and/xor, DATA_W-cycle shift-add mul.
// Optional PARAM_ALU_ILLEGAL_OP_ERR_EN adds an err port flagging illegal ops; otherwise they are ignored.
//
// state    | meaning
// S_IDLE   | waiting for start; latches operands and op on accept
// S_EXEC   | single-cycle op (add/and/xor, or illegal with err) completes next edge
// S_MUL    | one multiplier bit per cycle, completes after DATA_W iterations
// S_WAIT_LOW | done pulse issued; hold here until the master drops start
module param_alu_core #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic                  busy
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WAIT_LOW} state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [RES_W-1:0]   mcand;
  logic [DATA_W-1:0]  mplier;
  logic [RES_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [2:0]         op_code;
  logic               op_hi_zero;
  logic               op_single;
  logic               op_mul;
  logic [RES_W-1:0]   mul_sum;

  // Encodings live in the low 3 bits; any set upper bit makes the op illegal.
  always_comb begin
    op_code    = op[2:0];
    op_hi_zero = ((op >> 3) == '0);
    op_mul     = op_hi_zero && (op_code == OP_MUL);
    op_single  = op_hi_zero && (op_code inside {OP_ADD, OP_AND, OP_XOR});
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
    op_single  = op_single || !op_hi_zero || (op_code > OP_MUL);
`endif
    mul_sum    = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      op_q   <= OP_NOP;
      a_q    <= '0;
      b_q    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && op_single) begin
            state <= S_EXEC;
            busy  <= 1'b1;
            op_q  <= op_code;
            a_q   <= A;
            b_q   <= B;
          end else if (start && op_mul) begin
            state  <= S_MUL;
            busy   <= 1'b1;
            mcand  <= RES_W'(A);
            mplier <= B;
            acc    <= '0;
            cnt    <= CNT_W'(DATA_W - 1);
          end
        end
        S_EXEC: begin
          done  <= 1'b1;
          state <= S_WAIT_LOW;
          case (op_q)
            OP_ADD:  result <= RES_W'(a_q) + RES_W'(b_q);
            OP_AND:  result <= RES_W'(a_q & b_q);
            OP_XOR:  result <= RES_W'(a_q ^ b_q);
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
            default: err <= 1'b1;
`else
            default: ;
`endif
          endcase
        end
        S_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // Final iteration writes the completed sum straight to the result.
          if (cnt == '0) begin
            result <= mul_sum;
            done   <= 1'b1;
            state  <= S_WAIT_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_LOW: begin
          done <= 1'b0;
          busy <= 1'b0;
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
          err  <= 1'b0;
`endif
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu_core.sv
// Self-checking bench for param_alu_core (DATA_W=8): directed corner cases plus random commands
// compared against a plain-arithmetic reference model.
module tb_param_alu_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  A = 8'h00;
  logic [7:0]  B = 8'h00;
  logic        done;
  logic        busy;
  logic [15:0] result;
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
  logic        err;
  localparam int ILLEGAL_LAT = 1;
`else
  localparam int ILLEGAL_LAT = 0;
`endif

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_res = 16'h0000;

  param_alu_core #(.DATA_W(8), .OP_W(3)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .op(op),
    .A(A),
    .B(B),
    .done(done),
    .result(result),
    .busy(busy)
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Cycles from accept to done; 0 means the command never completes.
  function automatic int model_lat(input logic [2:0] o);
    case (o)
      3'd0:                return 0;
      3'd1, 3'd2, 3'd3:    return 1;
      3'd4:                return 8;
      default:             return ILLEGAL_LAT;
    endcase
  endfunction

  function automatic logic [15:0] model_res(input logic [2:0] o, input logic [7:0] a,
                                            input logic [7:0] b, input logic [15:0] prev);
    int unsigned ai = a;
    int unsigned bi = b;
    case (o)
      3'd1:    return 16'(ai + bi);
      3'd2:    return 16'(ai & bi);
      3'd3:    return 16'(ai ^ bi);
      3'd4:    return 16'(ai * bi);
      default: return prev;
    endcase
  endfunction

  task automatic run(input string tag, input logic [2:0] o, input logic [7:0] a,
                     input logic [7:0] b, input int hold, input int drop_at);
    int          elat;
    int          lat;
    int          ndone;
    int          nbusy;
    logic        busy0;
    logic        errv;
    logic [15:0] eres;
    logic [15:0] res_at_done;
    elat = model_lat(o);
    eres = model_res(o, a, b, exp_res);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    busy0 = busy;
    A = 8'($urandom);
    B = 8'($urandom);
    if (elat > 0) op = 3'($urandom);
    lat = -1; ndone = 0; nbusy = 0; errv = 1'b0; res_at_done = 16'h0000;
    for (int c = 1; c <= 14 + hold; c++) begin
      @(posedge clk); #1;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          res_at_done = result;
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
          errv = err;
`endif
        end
      end
      if (c == drop_at || (drop_at == 0 && ((lat >= 0 && c >= lat + hold) || c >= 10 + hold)))
        start = 1'b0;
    end
    chk({tag, "_ndone"}, ndone, (elat > 0) ? 1 : 0);
    chk({tag, "_lat"}, lat, (elat > 0) ? elat : -1);
    if (elat > 0) chk({tag, "_res_at_done"}, res_at_done, eres);
    chk({tag, "_res_held"}, result, eres);
    chk({tag, "_busy_accept"}, busy0, elat > 0);
    chk({tag, "_busy_cycles"}, nbusy, elat);
`ifdef PARAM_ALU_ILLEGAL_OP_ERR_EN
    if (elat > 0) chk({tag, "_err"}, errv, o > 3'd4);
    chk({tag, "_err_clear"}, err, 1'b0);
`endif
    exp_res = eres;
  endtask

  initial begin
    int ndone_rst;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk) reset_n = 1'b1;

    // Reset asserted three cycles into a multiply aborts it.
    @(negedge clk);
    start = 1'b1; op = 3'd4; A = 8'hFF; B = 8'hFF;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmul_done", done, 1'b0);
    chk("rstmul_result", result, 16'h0000);
    chk("rstmul_busy", busy, 1'b0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    ndone_rst = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone_rst++;
    end
    chk("rstmul_no_done", ndone_rst, 0);
    exp_res = 16'h0000;

    run("add_1_1", 3'd1, 8'h01, 8'h01, 0, 0);
    chk("add_1_1_val", result, 16'h0002);
    run("add_ff_01", 3'd1, 8'hFF, 8'h01, 0, 0);
    chk("add_ff_01_val", result, 16'h0100);
    run("add_max", 3'd1, 8'hFF, 8'hFF, 0, 0);
    chk("add_max_val", result, 16'h01FE);
    run("mul_max", 3'd4, 8'hFF, 8'hFF, 0, 0);
    chk("mul_max_val", result, 16'hFE01);
    run("mul_zero", 3'd4, 8'h00, 8'h5A, 0, 0);
    chk("mul_zero_val", result, 16'h0000);
    run("mul_drop", 3'd4, 8'h5A, 8'h3C, 0, 3);
    run("and_hold", 3'd2, 8'hF0, 8'h3C, 4, 0);
    chk("and_val", result, 16'h0030);
    run("xor_hold", 3'd3, 8'hF0, 8'h3C, 4, 0);
    chk("xor_val", result, 16'h00CC);
    run("nop", 3'd0, 8'h12, 8'h34, 0, 0);
    chk("nop_val", result, 16'h00CC);
    run("illegal7", 3'd7, 8'h55, 8'hAA, 0, 0);
    chk("illegal7_val", result, 16'h00CC);
    run("after_illegal", 3'd1, 8'h10, 8'h20, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run("rnd", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 2)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
